// File: rtl/tt_um_counter_sequencer_if.sv
// ---------------------------------------------------------------------------
// tt_um_counter_sequencer_if
// Purpose : bundles the Tiny Tapeout style I/O of the counter sequencer so
//           the block and its driver share one connection object.
// Signals : ena     - tile enable (ignored by the block)
//           ui_in   - [2:0] modulus select, [3] start, [4] pause, [5] abort
//           uio_in  - [7:4] wrap target
//           uo_out  - [2:0] count, [3] wrap pulse, [4] busy, [5] done,
//                     [7:6] state code
//           uio_out - [3:0] wraps completed, [7:4] zero
//           uio_oe  - output enables, constant 8'h0F
// Modports: master drives the inputs, slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface tt_um_counter_sequencer_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tt_um_counter_sequencer
// Purpose : modulo-M counter that runs until it has wrapped W times, with
//           pause (level) and abort controls. M and W are captured at start.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous, active-low reset
//           io    - slave side of tt_um_counter_sequencer_if (see there for
//                   the bit assignment of ui_in/uio_in/uo_out/uio_out)
// ---------------------------------------------------------------------------
module tt_um_counter_sequencer (
    input  logic                            clk,
    input  logic                            rst_n,
    tt_um_counter_sequencer_if.slave        io
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [3:0] wraps_q, wraps_d;
    logic       wrap_q,  wrap_d;
    logic [3:0] m_q,     m_d;      // modulus, 1..8
    logic [3:0] w_q,     w_d;      // wrap target, 0 = free-run
    logic       start_q;           // previous ui_in[3]
    logic       armed_q;           // low for the first clock after reset

    logic       start_in;
    logic       pause_in;
    logic       abort_in;
    logic       start_edge;
    logic       last_count;
    logic [3:0] wraps_inc;

    assign start_in  = io.ui_in[3];
    assign pause_in  = io.ui_in[4];
    assign abort_in  = io.ui_in[5];

    // The armed flag keeps a start level that is already high when reset
    // is released from looking like a rising edge on the first clock.
    assign start_edge = start_in & ~start_q & armed_q;

    assign last_count = ({1'b0, count_q} == (m_q - 4'd1));
    assign wraps_inc  = wraps_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            wraps_q <= 4'd0;
            wrap_q  <= 1'b0;
            m_q     <= 4'd6;
            w_q     <= 4'd0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wraps_q <= wraps_d;
            wrap_q  <= wrap_d;
            m_q     <= m_d;
            w_q     <= w_d;
            start_q <= start_in;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wraps_d = wraps_q;
        wrap_d  = 1'b0;
        m_d     = m_q;
        w_d     = w_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (abort_in) begin
                    state_d = IDLE;
                    count_d = 3'd0;
                    wraps_d = 4'd0;
                end else if (start_edge) begin
                    state_d = RUN;
                    count_d = 3'd0;
                    wraps_d = 4'd0;
                    m_d     = {1'b0, io.ui_in[2:0]} + 4'd1;
                    w_d     = io.uio_in[7:4];
                end
            end
            RUN: begin
                if (abort_in) begin
                    state_d = IDLE;
                    count_d = 3'd0;
                    wraps_d = 4'd0;
                end else if (pause_in) begin
                    state_d = PAUSE;
                end else if (last_count) begin
                    // M==1 lands here every cycle: count stays 0, pulse each clock.
                    count_d = 3'd0;
                    wrap_d  = 1'b1;
                    wraps_d = wraps_inc;
                    if ((w_q != 4'd0) && (wraps_inc == w_q)) begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            PAUSE: begin
                if (abort_in) begin
                    state_d = IDLE;
                    count_d = 3'd0;
                    wraps_d = 4'd0;
                end else if (!pause_in) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so they change on the
    // same edge as the state and fall to zero as soon as reset asserts.
    assign io.uo_out  = {state_q,
                         (state_q == DONE),
                         ((state_q == RUN) || (state_q == PAUSE)),
                         wrap_q,
                         count_q};
    assign io.uio_out = {4'b0000, wraps_q};
    assign io.uio_oe  = 8'h0F;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, io.ena, io.ui_in[7:6], io.uio_in[3:0]};

endmodule

// File: tb/tb_tt_um_counter_sequencer.sv
module tb_tt_um_counter_sequencer;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    tt_um_counter_sequencer_if io ();

    tt_um_counter_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uio;
        logic [1:0] st;
        logic       wrap;
        logic [2:0] cnt;
        logic [3:0] wraps;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] exp_uo(input logic [1:0] st, input logic wrap,
                                          input logic [2:0] cnt);
        logic d;
        logic b;
        d = (st == S_DONE);
        b = (st == S_RUN) || (st == S_PAUSE);
        return {st, d, b, wrap, cnt};
    endfunction

    task automatic add(input logic [7:0] ui, input logic [7:0] uio, input logic [1:0] st,
                       input logic wrap, input int cnt, input int wraps);
        vec_t v;
        v.ui    = ui;
        v.uio   = uio;
        v.st    = st;
        v.wrap  = wrap;
        v.cnt   = 3'(cnt);
        v.wraps = 4'(wraps);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] ui, input logic [7:0] uio);
        io.ui_in  = ui;
        io.uio_in = uio;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        io.ena    = 1'b1;
        io.ui_in  = 8'h00;
        io.uio_in = 8'h00;
        rst_n     = 1'b0;

        // Basic run: M=6, W=2
        add(8'h05, 8'h20, S_IDLE, 0, 0, 0);
        add(8'h0D, 8'h20, S_RUN,  0, 0, 0);
        for (int c = 1; c <= 5; c++) add(8'h05, 8'h20, S_RUN, 0, c, 0);
        add(8'h05, 8'h20, S_RUN, 1, 0, 1);
        for (int c = 1; c <= 5; c++) add(8'h05, 8'h20, S_RUN, 0, c, 1);
        add(8'h05, 8'h20, S_DONE, 1, 0, 2);
        add(8'h05, 8'h20, S_DONE, 0, 0, 2);
        // Restart from DONE: M=3, W=1
        add(8'h0A, 8'h10, S_RUN,  0, 0, 0);
        add(8'h02, 8'h10, S_RUN,  0, 1, 0);
        add(8'h02, 8'h10, S_RUN,  0, 2, 0);
        add(8'h02, 8'h10, S_DONE, 1, 0, 1);
        add(8'h02, 8'h10, S_DONE, 0, 0, 1);
        // Pause: M=4, W=1; W input changes and a start edge during PAUSE are ignored
        add(8'h0B, 8'h10, S_RUN,   0, 0, 0);
        add(8'h03, 8'h10, S_RUN,   0, 1, 0);
        add(8'h03, 8'h10, S_RUN,   0, 2, 0);
        add(8'h13, 8'hF0, S_PAUSE, 0, 2, 0);
        add(8'h1B, 8'hF0, S_PAUSE, 0, 2, 0);
        add(8'h13, 8'hF0, S_PAUSE, 0, 2, 0);
        add(8'h03, 8'hF0, S_RUN,   0, 2, 0);
        add(8'h03, 8'hF0, S_RUN,   0, 3, 0);
        add(8'h03, 8'hF0, S_DONE,  1, 0, 1);
        add(8'h03, 8'hF0, S_DONE,  0, 0, 1);
        // Abort: M=8, W=0, start held high afterwards
        add(8'h0F, 8'h00, S_RUN, 0, 0, 0);
        for (int c = 1; c <= 5; c++) add(8'h0F, 8'h00, S_RUN, 0, c, 0);
        add(8'h2F, 8'h00, S_IDLE, 0, 0, 0);
        add(8'h0F, 8'h00, S_IDLE, 0, 0, 0);
        add(8'h0F, 8'h00, S_IDLE, 0, 0, 0);
        add(8'h07, 8'h00, S_IDLE, 0, 0, 0);
        add(8'h0F, 8'h00, S_RUN,  0, 0, 0);
        add(8'h0F, 8'h00, S_RUN,  0, 1, 0);
        add(8'h27, 8'h00, S_IDLE, 0, 0, 0);
        add(8'h00, 8'h00, S_IDLE, 0, 0, 0);

        // Reset state
        #3;
        chk("reset_uo",      io.uo_out,  8'h00);
        chk("reset_uio_out", io.uio_out, 8'h00);
        chk("reset_uio_oe",  io.uio_oe,  8'h0F);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ui, vecs[i].uio);
            chk($sformatf("vec%0d_uo", i), io.uo_out,
                exp_uo(vecs[i].st, vecs[i].wrap, vecs[i].cnt));
            chk($sformatf("vec%0d_uio", i), io.uio_out, {4'b0000, vecs[i].wraps});
        end

        // Free-run with M=1, W=0: wrap every cycle, wraps rolls over, never DONE
        step(8'h08, 8'h00);
        chk("fr_start_uo",  io.uo_out,  exp_uo(S_RUN, 1'b0, 3'd0));
        chk("fr_start_uio", io.uio_out, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            step(8'h00, 8'h00);
            chk($sformatf("fr%0d_uo", i),  io.uo_out,  exp_uo(S_RUN, 1'b1, 3'd0));
            chk($sformatf("fr%0d_uio", i), io.uio_out, {4'b0000, 4'(i)});
        end
        step(8'h20, 8'h00);
        chk("fr_abort_uo", io.uo_out, 8'h00);

        // Async reset mid-RUN, start already high at release
        step(8'h0D, 8'h00);
        step(8'h05, 8'h00);
        step(8'h05, 8'h00);
        chk("ar_pre_uo", io.uo_out, exp_uo(S_RUN, 1'b0, 3'd2));
        #2;
        rst_n    = 1'b0;
        io.ui_in = 8'h08;
        #1;
        chk("ar_uo",      io.uo_out,  8'h00);
        chk("ar_uio_out", io.uio_out, 8'h00);
        chk("ar_uio_oe",  io.uio_oe,  8'h0F);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(8'h08, 8'h00);
            chk($sformatf("ar_hold%0d_uo", i), io.uo_out, 8'h00);
        end
        chk("ar_oe_after", io.uio_oe, 8'h0F);
        step(8'h00, 8'h00);
        step(8'h08, 8'h00);
        chk("ar_restart_uo", io.uo_out, exp_uo(S_RUN, 1'b0, 3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
